// File: rtl/hazard_scoreboard.sv
// Data-hazard unit: in-flight dest-tag pipeline, registered forward selects, load-use stall.
// Latency: stall is combinational from ID; fwd_a/fwd_b register on the edge the consumer enters EX.
// Backpressure: hold freezes everything; stall asks upstream to freeze PC/IF-ID and bubbles EX.
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = $clog2(FWD_STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic                  id_regwrite,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_memread,
    input  logic                  hold,
    input  logic                  flush,
    output logic                  stall,
    output logic [SEL_W-1:0]      fwd_a,
    output logic [SEL_W-1:0]      fwd_b,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam logic [SEL_W-1:0] ALU_AVAIL  = SEL_W'(1);
    localparam logic [SEL_W-1:0] LOAD_AVAIL = SEL_W'(1 + LOAD_LAT);

    // Only stages 0..FWD_STAGES-1 are stored: the final stage is already in the
    // register file, so it can never be a forwarding source.
    logic [FWD_STAGES-1:0] tag_prod;
    logic [REG_ADDR_W-1:0] tag_rd    [FWD_STAGES];
    logic [SEL_W-1:0]      tag_avail [FWD_STAGES];

    logic             hit_a, hit_b;
    logic [SEL_W-1:0] stg_a, stg_b;
    logic [SEL_W-1:0] avail_a, avail_b;
    logic             pend_a, pend_b;
    logic             issue;

    // Scan oldest to youngest so the youngest producer overwrites and wins.
    always_comb begin
        hit_a   = 1'b0;
        hit_b   = 1'b0;
        stg_a   = '0;
        stg_b   = '0;
        avail_a = '0;
        avail_b = '0;
        for (int s = FWD_STAGES - 1; s >= 0; s--) begin
            if (tag_prod[s] && tag_rd[s] == id_rs) begin
                hit_a   = 1'b1;
                stg_a   = SEL_W'(s);
                avail_a = tag_avail[s];
            end
            if (tag_prod[s] && tag_rd[s] == id_rt) begin
                hit_b   = 1'b1;
                stg_b   = SEL_W'(s);
                avail_b = tag_avail[s];
            end
        end
    end

    always_comb begin
        pend_a = id_use_rs && (id_rs != '0) && hit_a && (avail_a > stg_a + SEL_W'(1));
        pend_b = id_use_rt && (id_rt != '0) && hit_b && (avail_b > stg_b + SEL_W'(1));
        stall  = id_valid && !flush && (pend_a || pend_b);
        issue  = id_valid && !flush && !stall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_prod     <= '0;
            fwd_a        <= '0;
            fwd_b        <= '0;
            stall_cycles <= '0;
            for (int k = 0; k < FWD_STAGES; k++) begin
                tag_rd[k]    <= '0;
                tag_avail[k] <= '0;
            end
        end else if (!hold) begin
            for (int k = FWD_STAGES - 1; k > 0; k--) begin
                tag_prod[k]  <= tag_prod[k-1];
                tag_rd[k]    <= tag_rd[k-1];
                tag_avail[k] <= tag_avail[k-1];
            end
            tag_prod[0]  <= issue && id_regwrite && (id_rd != '0);
            tag_rd[0]    <= id_rd;
            tag_avail[0] <= id_memread ? LOAD_AVAIL : ALU_AVAIL;

            fwd_a <= (issue && id_use_rs && id_rs != '0 && hit_a) ? stg_a + SEL_W'(1) : '0;
            fwd_b <= (issue && id_use_rt && id_rt != '0 && hit_b) ? stg_b + SEL_W'(1) : '0;

            if (stall && stall_cycles != '1)
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    typedef struct packed {
        logic       vld;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       rw;
        logic [4:0] rd;
        logic       mr;
    } ins_t;

    typedef struct {
        string      nm;
        logic       stall;
        logic [1:0] fa;
        logic [1:0] fb;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread, hold, flush;
    logic [4:0] id_rs, id_rt, id_rd;

    logic        stall_s, stall_d;
    logic [1:0]  fa_s, fb_s, fa_d, fb_d;
    logic [15:0] cnt_s, cnt_d;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_cnt = 0;
    logic sel_deep = 1'b0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    hazard_scoreboard dut_s (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_regwrite(id_regwrite),
        .id_rd(id_rd), .id_memread(id_memread), .hold(hold), .flush(flush),
        .stall(stall_s), .fwd_a(fa_s), .fwd_b(fb_s), .stall_cycles(cnt_s)
    );

    hazard_scoreboard #(.FWD_STAGES(3), .LOAD_LAT(2)) dut_d (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_regwrite(id_regwrite),
        .id_rd(id_rd), .id_memread(id_memread), .hold(hold), .flush(flush),
        .stall(stall_d), .fwd_a(fa_d), .fwd_b(fb_d), .stall_cycles(cnt_d)
    );

    function automatic ins_t alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        alu = '{vld: 1'b1, rs: rs, rt: rt, urs: 1'b1, urt: 1'b1, rw: 1'b1, rd: rd, mr: 1'b0};
    endfunction

    function automatic ins_t lw(input logic [4:0] rd, input logic [4:0] rs);
        lw = '{vld: 1'b1, rs: rs, rt: 5'd0, urs: 1'b1, urt: 1'b0, rw: 1'b1, rd: rd, mr: 1'b1};
    endfunction

    function automatic ins_t nop();
        nop = '0;
    endfunction

    // Called at posedge+1: drive ID, check stall mid-cycle, check fwd after the edge.
    task automatic step(input ins_t i, input logic h, input logic f, input logic es,
                        input logic [1:0] efa, input logic [1:0] efb, input string nm);
        exp_t e;
        logic so;
        logic [1:0] ao, bo;
        id_valid = i.vld; id_rs = i.rs; id_rt = i.rt; id_use_rs = i.urs; id_use_rt = i.urt;
        id_regwrite = i.rw; id_rd = i.rd; id_memread = i.mr; hold = h; flush = f;
        exp_q.push_back('{nm, es, efa, efb});
        #3;
        e  = exp_q.pop_front();
        so = sel_deep ? stall_d : stall_s;
        n_tests++;
        if (so !== e.stall) begin
            n_fail++;
            $display("FAIL %s stall: got %b want %b", e.nm, so, e.stall);
        end
        @(posedge clk);
        #1;
        ao = sel_deep ? fa_d : fa_s;
        bo = sel_deep ? fb_d : fb_s;
        n_tests++;
        if (ao !== e.fa) begin
            n_fail++;
            $display("FAIL %s fwd_a: got %0d want %0d", e.nm, ao, e.fa);
        end
        n_tests++;
        if (bo !== e.fb) begin
            n_fail++;
            $display("FAIL %s fwd_b: got %0d want %0d", e.nm, bo, e.fb);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(nop(), 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, "idle");
    endtask

    task automatic check_cnt(input string nm);
        logic [15:0] c;
        c = sel_deep ? cnt_d : cnt_s;
        n_tests++;
        if (c !== 16'(exp_cnt)) begin
            n_fail++;
            $display("FAIL %s stall_cycles: got %0d want %0d", nm, c, exp_cnt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd2; id_use_rs = 1'b1; id_use_rt = 1'b1;
        id_regwrite = 1'b1; id_rd = 5'd3; id_memread = 1'b0; hold = 1'b0; flush = 1'b0;
        #2;
        n_tests++;
        if ({stall_s, fa_s, fb_s} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset outputs: got stall=%b fa=%0d fb=%0d want 0", stall_s, fa_s, fb_s);
        end
        check_cnt("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_alu_b2b();
        step(alu(5, 1, 2), 0, 0, 0, 0, 0, "alu_prod");
        step(alu(6, 5, 2), 0, 0, 0, 1, 0, "alu_cons");
        idle(2);
    endtask

    task automatic test_load_use();
        step(lw(5, 1),     0, 0, 0, 0, 0, "lu_load");
        step(alu(7, 2, 5), 0, 0, 1, 0, 0, "lu_stall");
        step(alu(7, 2, 5), 0, 0, 0, 0, 2, "lu_fwd");
        exp_cnt = 1;
        check_cnt("lu_cnt");
        idle(2);
    endtask

    task automatic test_shadow();
        step(alu(7, 1, 2),  0, 0, 0, 0, 0, "sh_old");
        step(alu(7, 1, 2),  0, 0, 0, 0, 0, "sh_new");
        step(alu(8, 7, 3),  0, 0, 0, 1, 0, "sh_youngest");
        idle(2);
        step(alu(7, 1, 2),  0, 0, 0, 0, 0, "sh_single");
        step(nop(),         0, 0, 0, 0, 0, "sh_gap");
        step(alu(9, 7, 1),  0, 0, 0, 2, 0, "sh_older");
        step(alu(10, 9, 9), 0, 0, 0, 1, 1, "sh_same_src");
        step(alu(0, 1, 2),  0, 0, 0, 0, 0, "sh_r0_write");
        step(alu(11, 0, 0), 0, 0, 0, 0, 0, "sh_r0_use");
        step(alu(3, 1, 2),  0, 0, 0, 0, 0, "sp_p3");
        step(alu(4, 1, 2),  0, 0, 0, 0, 0, "sp_p4");
        step(alu(12, 3, 4), 0, 0, 0, 2, 1, "sp_split");
        idle(2);
    endtask

    task automatic test_hold();
        step(alu(4, 1, 2), 0, 0, 0, 0, 0, "hd_p4");
        step(lw(5, 4),     0, 0, 0, 1, 0, "hd_load");
        for (int k = 0; k < 3; k++) step(alu(7, 2, 5), 1, 0, 1, 1, 0, "hd_frozen");
        check_cnt("hd_cnt_frozen");
        step(alu(7, 2, 5), 0, 0, 1, 0, 0, "hd_stall");
        step(alu(7, 2, 5), 0, 0, 0, 0, 2, "hd_fwd");
        exp_cnt = 2;
        check_cnt("hd_cnt");
        idle(2);
    endtask

    task automatic test_flush();
        step(lw(5, 1),     0, 0, 0, 0, 0, "fl_load");
        step(alu(7, 5, 2), 0, 1, 0, 0, 0, "fl_flush");
        step(alu(8, 5, 1), 0, 0, 0, 2, 0, "fl_after");
        check_cnt("fl_cnt");
        idle(2);
    endtask

    task automatic test_async_reset();
        step(alu(4, 1, 2), 0, 0, 0, 0, 0, "ar_p4");
        step(lw(5, 4),     0, 0, 0, 1, 0, "ar_load");
        id_valid = 1'b1; id_rs = 5'd5; id_rt = 5'd2; id_use_rs = 1'b1; id_use_rt = 1'b1;
        id_regwrite = 1'b1; id_rd = 5'd7; id_memread = 1'b0; hold = 1'b0; flush = 1'b0;
        #3;
        n_tests++;
        if (stall_s !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_pre_stall: got %b want 1", stall_s);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({stall_s, fa_s, fb_s} !== 5'b0) begin
            n_fail++;
            $display("FAIL ar_cleared: got stall=%b fa=%0d fb=%0d want 0", stall_s, fa_s, fb_s);
        end
        exp_cnt = 0;
        check_cnt("ar_cnt");
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(alu(8, 1, 2), 0, 0, 0, 0, 0, "ar_post");
        idle(3);
    endtask

    task automatic test_deep();
        sel_deep = 1'b1;
        exp_cnt  = 0;
        check_cnt("dp_cnt_start");
        step(lw(3, 1),     0, 0, 0, 0, 0, "dp_load");
        step(alu(6, 3, 2), 0, 0, 1, 0, 0, "dp_stall1");
        step(alu(6, 3, 2), 0, 0, 1, 0, 0, "dp_stall2");
        step(alu(6, 3, 2), 0, 0, 0, 3, 0, "dp_fwd");
        exp_cnt = 2;
        check_cnt("dp_cnt");
        idle(3);
        sel_deep = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_b2b();
        test_load_use();
        test_shadow();
        test_hold();
        test_flush();
        test_async_reset();
        test_deep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
